// File: rtl/demux4_buf.sv
// demux4_buf: steers an input nibble into one of two independent 2-entry
// first-word-fall-through FIFOs (channel A for in_sel = 0, channel B for in_sel = 1).

module demux4_buf_chan #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_req_i,
   output logic [WIDTH-1:0] data_o,
   output logic             valid_o,
   output logic             full_o
);

   logic [WIDTH-1:0] mem_q [2];
   logic [WIDTH-1:0] mem_d [2];
   logic             wr_ptr_q, wr_ptr_d;
   logic             rd_ptr_q, rd_ptr_d;
   logic [1:0]       count_q, count_d;
   logic             push, pop;

   // Both push and pop are qualified here, so count cannot leave 0..DEPTH.
   assign push = push_i && (count_q != 2'(DEPTH));
   assign pop  = pop_req_i && (count_q != 2'd0);

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         mem_d[wr_ptr_q] = data_i;
         wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop) begin
         rd_ptr_d = ~rd_ptr_q;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Output is a mux of registers only: nothing from data_i reaches it in the same cycle.
   assign data_o  = mem_q[rd_ptr_q];
   assign valid_o = (count_q != 2'd0);
   assign full_o  = (count_q == 2'(DEPTH));

endmodule

module demux4_buf #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 2   // only 2 is supported
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_sel,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out_a_data,
   output logic             out_a_valid,
   input  logic             out_a_ready,
   output logic [WIDTH-1:0] out_b_data,
   output logic             out_b_valid,
   input  logic             out_b_ready
);

   // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
   // in_ready reflects only the selected channel's fullness, never the consumer's ready.
   logic full_a, full_b;
   logic push_a, push_b;

   assign in_ready = in_sel ? ~full_b : ~full_a;
   assign push_a   = in_valid && in_ready && !in_sel;
   assign push_b   = in_valid && in_ready &&  in_sel;

   demux4_buf_chan #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_chan_a (
      .clk       (clk),
      .rst       (rst),
      .push_i    (push_a),
      .data_i    (in_data),
      .pop_req_i (out_a_ready),
      .data_o    (out_a_data),
      .valid_o   (out_a_valid),
      .full_o    (full_a)
   );

   demux4_buf_chan #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_chan_b (
      .clk       (clk),
      .rst       (rst),
      .push_i    (push_b),
      .data_i    (in_data),
      .pop_req_i (out_b_ready),
      .data_o    (out_b_data),
      .valid_o   (out_b_valid),
      .full_o    (full_b)
   );

endmodule

// File: tb/tb_demux4_buf.sv
// Directed bench for demux4_buf: reset, steering, backpressure, simultaneous
// push/pop, pointer wrap with a scoreboard, and reset mid-operation.

module tb_demux4_buf;

   logic       clk;
   logic       rst;
   logic [3:0] in_data;
   logic       in_sel;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] out_a_data;
   logic       out_a_valid;
   logic       out_a_ready;
   logic [3:0] out_b_data;
   logic       out_b_valid;
   logic       out_b_ready;

   int n_cmp;
   int n_err;
   logic [3:0] exp_q[$];

   demux4_buf #(.WIDTH(4), .DEPTH(2)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_data     (in_data),
      .in_sel      (in_sel),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .out_a_data  (out_a_data),
      .out_a_valid (out_a_valid),
      .out_a_ready (out_a_ready),
      .out_b_data  (out_b_data),
      .out_b_valid (out_b_valid),
      .out_b_ready (out_b_ready)
   );

   // clock / reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after a rising edge; checks happen there too.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic s, input logic [3:0] d);
      in_valid = v;
      in_sel   = s;
      in_data  = d;
      #1;
   endtask

   initial begin
      int rx_cnt;
      int tx_cnt;
      int cyc;
      logic a_seen;
      logic [3:0] exp_v;

      n_cmp = 0;
      n_err = 0;
      rst = 1'b1;
      in_data = '0; in_sel = 1'b0; in_valid = 1'b0;
      out_a_ready = 1'b0; out_b_ready = 1'b0;
      tick(); tick();
      rst = 1'b0;
      #1;

      // reset asserted between edges with data buffered
      drive(1'b1, 1'b0, 4'h9);
      tick();
      drive(1'b0, 1'b0, 4'h0);
      check_eq("pre_rst_a_valid", 8'(out_a_valid), 8'h1);
      rst = 1'b1;
      #1;
      check_eq("rst_a_valid", 8'(out_a_valid), 8'h0);
      check_eq("rst_b_valid", 8'(out_b_valid), 8'h0);
      check_eq("rst_a_data", 8'(out_a_data), 8'h0);
      check_eq("rst_b_data", 8'(out_b_data), 8'h0);
      check_eq("rst_in_ready", 8'(in_ready), 8'h1);
      tick();
      rst = 1'b0;
      #1;

      // steering
      drive(1'b1, 1'b0, 4'h5);
      check_eq("steer_ready_a", 8'(in_ready), 8'h1);
      check_eq("steer_no_same_cycle", 8'(out_a_valid), 8'h0);
      tick();
      check_eq("steer_a_valid", 8'(out_a_valid), 8'h1);
      check_eq("steer_a_data", 8'(out_a_data), 8'h5);
      check_eq("steer_b_empty", 8'(out_b_valid), 8'h0);
      drive(1'b1, 1'b1, 4'hA);
      tick();
      drive(1'b0, 1'b0, 4'h0);
      check_eq("steer_b_valid", 8'(out_b_valid), 8'h1);
      check_eq("steer_b_data", 8'(out_b_data), 8'hA);
      check_eq("steer_a_hold", 8'(out_a_data), 8'h5);
      out_a_ready = 1'b1; out_b_ready = 1'b1;
      tick();
      out_a_ready = 1'b0; out_b_ready = 1'b0;
      check_eq("steer_drain_a", 8'(out_a_valid), 8'h0);
      check_eq("steer_drain_b", 8'(out_b_valid), 8'h0);

      // full / backpressure on channel A
      drive(1'b1, 1'b0, 4'h1); tick();
      drive(1'b1, 1'b0, 4'h2); tick();
      drive(1'b1, 1'b0, 4'h3);
      check_eq("full_ready_a", 8'(in_ready), 8'h0);
      drive(1'b1, 1'b1, 4'h3);
      check_eq("full_ready_sel_b", 8'(in_ready), 8'h1);
      drive(1'b1, 1'b0, 4'h3);
      tick();
      check_eq("full_held_data", 8'(out_a_data), 8'h1);
      check_eq("full_b_untouched", 8'(out_b_valid), 8'h0);
      out_a_ready = 1'b1;
      #1;
      check_eq("full_no_bypass", 8'(in_ready), 8'h0);
      check_eq("full_pop1", 8'(out_a_data), 8'h1);
      tick();
      check_eq("full_pop2", 8'(out_a_data), 8'h2);
      check_eq("full_ready_after_pop", 8'(in_ready), 8'h1);
      tick();
      drive(1'b0, 1'b0, 4'h0);
      check_eq("full_pop3", 8'(out_a_data), 8'h3);
      check_eq("full_pop3_valid", 8'(out_a_valid), 8'h1);
      tick();
      out_a_ready = 1'b0;
      check_eq("full_empty", 8'(out_a_valid), 8'h0);

      // simultaneous push/pop with count 1
      drive(1'b1, 1'b0, 4'h4); tick();
      drive(1'b0, 1'b0, 4'h0);
      check_eq("sim_head", 8'(out_a_data), 8'h4);
      drive(1'b1, 1'b0, 4'h7);
      out_a_ready = 1'b1;
      tick();
      out_a_ready = 1'b0;
      drive(1'b0, 1'b0, 4'h0);
      check_eq("sim_data", 8'(out_a_data), 8'h7);
      check_eq("sim_valid", 8'(out_a_valid), 8'h1);
      drive(1'b1, 1'b0, 4'h8); tick();
      drive(1'b1, 1'b0, 4'h0);
      check_eq("sim_count2_full", 8'(in_ready), 8'h0);
      drive(1'b0, 1'b0, 4'h0);
      out_a_ready = 1'b1;
      tick();
      check_eq("sim_second", 8'(out_a_data), 8'h8);
      tick();
      out_a_ready = 1'b0;
      check_eq("sim_drained", 8'(out_a_valid), 8'h0);

      // wrap-around stream to B with random consumer backpressure
      exp_q.delete();
      rx_cnt = 0;
      tx_cnt = 0;
      a_seen = 1'b0;
      cyc = 0;
      while (rx_cnt < 16 && cyc < 300) begin
         in_valid    = (tx_cnt < 16);
         in_sel      = 1'b1;
         in_data     = 4'(tx_cnt);
         out_b_ready = 1'($urandom_range(0, 1));
         #1;
         if (out_b_valid && out_b_ready) begin
            if (exp_q.size() == 0) begin
               check_eq("wrap_unexpected", 8'(out_b_data), 8'hFF);
            end else begin
               exp_v = exp_q.pop_front();
               check_eq("wrap_order", 8'(out_b_data), 8'(exp_v));
            end
            rx_cnt++;
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(in_data);
            tx_cnt++;
         end
         if (out_a_valid) a_seen = 1'b1;
         tick();
         cyc++;
      end
      in_valid = 1'b0;
      out_b_ready = 1'b0;
      #1;
      check_eq("wrap_rx_count", 8'(rx_cnt), 8'd16);
      check_eq("wrap_none_on_a", 8'(a_seen), 8'h0);
      check_eq("wrap_b_empty", 8'(out_b_valid), 8'h0);

      // reset mid-operation with both channels full
      drive(1'b1, 1'b0, 4'h1); tick();
      drive(1'b1, 1'b0, 4'h2); tick();
      drive(1'b1, 1'b1, 4'h3); tick();
      drive(1'b1, 1'b1, 4'h4); tick();
      check_eq("mid_full_b", 8'(in_ready), 8'h0);
      drive(1'b1, 1'b0, 4'h5);
      check_eq("mid_full_a", 8'(in_ready), 8'h0);
      rst = 1'b1;
      out_a_ready = 1'b1;
      #1;
      check_eq("mid_rst_a_valid", 8'(out_a_valid), 8'h0);
      check_eq("mid_rst_b_valid", 8'(out_b_valid), 8'h0);
      check_eq("mid_rst_ready", 8'(in_ready), 8'h1);
      tick();
      check_eq("mid_rst_no_push", 8'(out_a_valid), 8'h0);
      rst = 1'b0;
      out_a_ready = 1'b0;
      drive(1'b0, 1'b0, 4'h0);
      check_eq("mid_post_empty", 8'(out_a_valid), 8'h0);
      drive(1'b1, 1'b0, 4'hC);
      check_eq("mid_accept_cycle", 8'(out_a_valid), 8'h0);
      tick();
      drive(1'b0, 1'b0, 4'h0);
      check_eq("mid_push_valid", 8'(out_a_valid), 8'h1);
      check_eq("mid_push_data", 8'(out_a_data), 8'hC);
      check_eq("mid_b_still_empty", 8'(out_b_valid), 8'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/demux4_buf.md
DEMUX4_BUF -- requirements
Module: demux4_buf

Interface
REQ-001 Parameter: WIDTH, 4, data width of the input nibble and of each output channel.
REQ-002 Parameter: DEPTH, 2, entries per output channel buffer; only the value 2 is supported.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_data  input  WIDTH  nibble to be steered.
REQ-006 in_sel  input  1  destination: 0 routes to channel A, 1 routes to channel B.
REQ-007 in_valid  input  1  in_data/in_sel valid this cycle.
REQ-008 in_ready  output  1  block accepts the offered nibble this cycle.
REQ-009 out_a_data  output  WIDTH  head entry of channel A.
REQ-010 out_a_valid  output  1  channel A holds at least one entry.
REQ-011 out_a_ready  input  1  consumer of channel A takes the head entry.
REQ-012 out_b_data, out_b_valid, out_b_ready: same as REQ-009..011 for channel B.

Function
REQ-013 Each channel SHALL be an independent 2-entry FIFO (storage, read pointer, write pointer, 2-bit count 0..2).
REQ-014 in_ready SHALL be combinational: 1 when the channel chosen by in_sel has count < 2, else 0; in_ready SHALL NOT depend on out_x_ready (no bypass when full).
REQ-015 Push: in_valid & in_ready at a rising edge SHALL write in_data into the selected channel at its write pointer and advance that pointer.
REQ-016 Pop: out_x_valid & out_x_ready at a rising edge SHALL advance that channel's read pointer; out_x_ready while out_x_valid = 0 SHALL have no effect.
REQ-017 out_x_valid SHALL equal (count_x != 0); out_x_data SHALL present storage at the read pointer (first-word fall-through), registered, with no combinational path from in_data.
REQ-018 Latency: a nibble accepted at edge N SHALL appear on out_x_data with out_x_valid = 1 after edge N (visible in cycle N+1), never in the acceptance cycle.
REQ-019 Simultaneous push and pop on the same channel with count = 1 SHALL leave count at 1 and preserve FIFO order; with count = 2, a pop SHALL proceed and the push SHALL be refused (in_ready was 0).
REQ-020 A push to one channel and a pop from the other in the same cycle SHALL both complete independently.
REQ-021 Pointers SHALL be 1 bit and wrap 1 -> 0; count SHALL never exceed 2 or underflow below 0.
REQ-022 Per-channel ordering SHALL be strict FIFO; no nibble SHALL be dropped, duplicated, or delivered to the non-selected channel.
REQ-023 in_sel and in_data are ignored when in_valid = 0; in_sel is sampled only in the push cycle.

Reset
REQ-024 While rst = 1, all counts, pointers, and storage SHALL be forced to 0 immediately, independent of clk.
REQ-025 Reset values: out_a_valid = out_b_valid = 0, out_a_data = out_b_data = 0, in_ready = 1.
REQ-026 Reset asserted mid-transfer SHALL discard all buffered entries; no pop or push in the reset cycle takes effect.
REQ-027 After rst deasserts, the first rising edge with in_valid & in_ready SHALL perform a normal push.

Verification
REQ-028 Reset: assert rst between edges -> out_a_valid = out_b_valid = 0, out_x_data = 0, in_ready = 1 without a clock edge.
REQ-029 Steering: push 0x5 sel 0, then 0xA sel 1, ready low -> out_a_data = 0x5, out_b_data = 0xA, both valid one cycle after each push.
REQ-030 Full/backpressure: push 0x1, 0x2, 0x3 to A with out_a_ready = 0 -> in_ready = 0 for sel 0 after two pushes, 0x3 held off, in_ready = 1 when sel = 1; release out_a_ready -> order 0x1, 0x2, 0x3.
REQ-031 Simultaneous: channel A count 1 holding 0x4, push 0x7 to A with out_a_ready = 1 -> 0x4 popped, out_a_data = 0x7, count stays 1.
REQ-032 Wrap-around: stream 0x0..0xF to B with out_b_ready toggling randomly -> all 16 values received in order, none on A.
REQ-033 Reset mid-operation: both channels full, assert rst -> both valids 0 immediately; after release, push 0xC to A -> out_a_data = 0xC next cycle.
